// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC readout: FSM states, code-width helper,
// and the default delay-line geometry shared with the delay-line instantiation.
package tdc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PULSE,
      ST_CAPTURE,
      ST_DECODE,
      ST_OUT
   } tdc_state_t;

   localparam int TDC_N_DELAY    = 32;
   localparam int TDC_N_AVG_LOG2 = 2;
   localparam int TDC_PULSE_CYC  = 1;
   localparam int TDC_CAP_CYC    = 1;

   // Width needed to hold a tap count in 0..n_delay
   function automatic int tdc_cw(input int n_delay);
      return $clog2(n_delay + 1);
   endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Combinational thermometer-to-binary decode with bubble/saturation flags.
// TDC_BUBBLE_CORRECT_EN selects popcount decode instead of lowest-zero priority.
module tdc_therm_decode
   import tdc_pkg::*;
#(
   parameter int N_DELAY = TDC_N_DELAY,
   localparam int CW     = tdc_cw(N_DELAY)
) (
   input  logic [N_DELAY-1:0] i_word,
   output logic [CW-1:0]      o_code,
   output logic               o_bubble,
   output logic               o_ovf
);

   logic [N_DELAY-1:0] w_word_inc;
   logic [CW-1:0]      w_code;

   // A clean thermometer word is 2^k-1, so word & (word+1) is zero exactly then
   assign w_word_inc = i_word + N_DELAY'(1);
   assign o_bubble   = |(i_word & w_word_inc);
   assign o_ovf      = &i_word;

`ifdef TDC_BUBBLE_CORRECT_EN
   always_comb begin
      w_code = '0;
      for (int i = 0; i < N_DELAY; i++) begin
         w_code = w_code + CW'(i_word[i]);
      end
   end
`else
   always_comb begin
      w_code = CW'(N_DELAY);
      for (int i = N_DELAY - 1; i >= 0; i--) begin
         if (!i_word[i]) begin
            w_code = CW'(i);
         end
      end
   end
`endif

   assign o_code = w_code;

endmodule

// File: rtl/tdc_readout.sv
// TDC readout controller: launches the delay line, decodes and averages
// 2^N_AVG_LOG2 snapshots, delivers the result over valid/ready.
// Optional build macro: TDC_BUBBLE_CORRECT_EN (popcount decode, in tdc_therm_decode).
module tdc_readout
   import tdc_pkg::*;
#(
   parameter int N_DELAY    = TDC_N_DELAY,
   parameter int N_AVG_LOG2 = TDC_N_AVG_LOG2,
   parameter int PULSE_CYC  = TDC_PULSE_CYC,
   parameter int CAP_CYC    = TDC_CAP_CYC,
   localparam int CW        = tdc_cw(N_DELAY)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               meas_req,
   output logic               meas_busy,
   output logic               tdc_start,
   input  logic [N_DELAY-1:0] tdc_count,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CW-1:0]      res_data,
   output logic               res_bubble,
   output logic               res_ovf
);

   localparam int ACW   = CW + N_AVG_LOG2;
   localparam int SW    = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
   localparam int NS    = 1 << N_AVG_LOG2;
   localparam int PMAX  = (PULSE_CYC > CAP_CYC) ? PULSE_CYC : CAP_CYC;
   localparam int PHW   = $clog2(PMAX + 1);

   tdc_state_t       r_state;
   tdc_state_t       w_state_next;
   logic [PHW-1:0]   r_phase;
   logic [SW-1:0]    r_sample;
   logic [ACW-1:0]   r_acc;
   logic             r_bubble;
   logic             r_ovf;
   logic             r_tdc_start;
   logic             r_busy;
   logic             r_valid;
   logic [CW-1:0]    r_res_data;
   logic             r_res_bubble;
   logic             r_res_ovf;

   logic [CW-1:0]    w_code;
   logic             w_bubble;
   logic             w_ovf;
   logic             w_last;
   logic [ACW-1:0]   w_acc_sum;
   logic             w_bubble_sum;
   logic             w_ovf_sum;

   tdc_therm_decode #(
      .N_DELAY (N_DELAY)
   ) u_decode (
      .i_word   (tdc_count),
      .o_code   (w_code),
      .o_bubble (w_bubble),
      .o_ovf    (w_ovf)
   );

   assign w_last       = (r_sample == SW'(NS - 1));
   assign w_acc_sum    = r_acc + ACW'(w_code);
   assign w_bubble_sum = r_bubble | w_bubble;
   assign w_ovf_sum    = r_ovf | w_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (meas_req) begin
               w_state_next = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (r_phase == PHW'(PULSE_CYC - 1)) begin
               w_state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (r_phase == PHW'(CAP_CYC - 1)) begin
               w_state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_state_next = w_last ? ST_OUT : ST_PULSE;
         end
         ST_OUT: begin
            if (res_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Phase counter restarts on every state change; only PULSE/CAPTURE consult it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
      end else if (w_state_next != r_state) begin
         r_phase <= '0;
      end else if (r_state == ST_PULSE || r_state == ST_CAPTURE) begin
         r_phase <= r_phase + PHW'(1);
      end
   end

   // Outputs are registered from the next state so they align with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdc_start  <= 1'b0;
         r_busy       <= 1'b0;
         r_valid      <= 1'b0;
         r_sample     <= '0;
         r_acc        <= '0;
         r_bubble     <= 1'b0;
         r_ovf        <= 1'b0;
         r_res_data   <= '0;
         r_res_bubble <= 1'b0;
         r_res_ovf    <= 1'b0;
      end else begin
         r_tdc_start <= (w_state_next == ST_PULSE);
         r_busy      <= (w_state_next != ST_IDLE);
         r_valid     <= (w_state_next == ST_OUT);
         case (r_state)
            ST_IDLE: begin
               if (meas_req) begin
                  r_sample <= '0;
                  r_acc    <= '0;
                  r_bubble <= 1'b0;
                  r_ovf    <= 1'b0;
               end
            end
            ST_DECODE: begin
               r_acc    <= w_acc_sum;
               r_bubble <= w_bubble_sum;
               r_ovf    <= w_ovf_sum;
               if (w_last) begin
                  r_res_data   <= CW'(w_acc_sum >> N_AVG_LOG2);
                  r_res_bubble <= w_bubble_sum;
                  r_res_ovf    <= w_ovf_sum;
               end else begin
                  r_sample <= r_sample + SW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign tdc_start  = r_tdc_start;
   assign meas_busy  = r_busy;
   assign res_valid  = r_valid;
   assign res_data   = r_res_data;
   assign res_bubble = r_res_bubble;
   assign res_ovf    = r_res_ovf;

endmodule

// File: tb/tb_tdc_readout.sv
// Scoreboard bench for tdc_readout: directed snapshot batches, expected results
// queued at request time and checked by an independent monitor on res_valid.
module tb_tdc_readout;

   localparam int N_DELAY = 32;
   localparam int CW      = 6;
   localparam int LAT     = 1 + 4 * (1 + 1 + 1);

   typedef struct {
      logic [CW-1:0] d;
      logic          b;
      logic          o;
      int            cyc;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               meas_req;
   logic               meas_busy;
   logic               tdc_start;
   logic [N_DELAY-1:0] tdc_count;
   logic               res_valid;
   logic               res_ready;
   logic [CW-1:0]      res_data;
   logic               res_bubble;
   logic               res_ovf;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t exp_q[$];
   logic prev_valid = 1'b0;

   tdc_readout dut (
      .clk        (clk),
      .rst        (rst),
      .meas_req   (meas_req),
      .meas_busy  (meas_busy),
      .tdc_start  (tdc_start),
      .tdc_count  (tdc_count),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_bubble (res_bubble),
      .res_ovf    (res_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: each rising res_valid is one delivered result
   always @(negedge clk) begin
      if (res_valid === 1'b1 && prev_valid !== 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(res_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("res_data", 64'(res_data), 64'(e.d));
            chk("res_bubble", 64'(res_bubble), 64'(e.b));
            chk("res_ovf", 64'(res_ovf), 64'(e.o));
            chk("latency", 64'(cyc - e.cyc), 64'(LAT));
            $display("[TB] result data=%0d bubble=%0b ovf=%0b latency=%0d",
                     res_data, res_bubble, res_ovf, cyc - e.cyc);
         end
      end
      prev_valid = res_valid;
   end

   task automatic wait_start(input logic level);
      int n;
      n = 0;
      while (tdc_start !== level && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("tdc_start_timeout", 64'(tdc_start), 64'(level));
   endtask

   task automatic run_meas(input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3,
                           input logic [CW-1:0] d, input logic b, input logic o,
                           input int hold);
      logic [31:0] s[4];
      exp_t e;
      int   n;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      res_ready = (hold == 0);
      e.d = d; e.b = b; e.o = o; e.cyc = cyc;
      exp_q.push_back(e);
      meas_req = 1'b1;
      @(negedge clk);
      meas_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_start(1'b1);
         tdc_count = s[k];
         wait_start(1'b0);
      end
      n = 0;
      while (res_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("res_valid_timeout", 64'(res_valid), 64'd1);
      for (int i = 0; i < hold; i++) begin
         meas_req = i[0];
         chk("bp_valid", 64'(res_valid), 64'd1);
         chk("bp_busy", 64'(meas_busy), 64'd1);
         chk("bp_data", 64'(res_data), 64'(d));
         chk("bp_bubble", 64'(res_bubble), 64'(b));
         chk("bp_ovf", 64'(res_ovf), 64'(o));
         @(negedge clk);
      end
      meas_req  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      chk("valid_after_accept", 64'(res_valid), 64'd0);
      chk("busy_after_accept", 64'(meas_busy), 64'd0);
      @(negedge clk);
      chk("idle_busy", 64'(meas_busy), 64'd0);
      chk("idle_data_kept", 64'(res_data), 64'(d));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst       = 1'b1;
      meas_req  = 1'b0;
      res_ready = 1'b1;
      tdc_count = '0;
      repeat (3) @(negedge clk);
      chk("rst_start", 64'(tdc_start), 64'd0);
      chk("rst_busy", 64'(meas_busy), 64'd0);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_data", 64'(res_data), 64'd0);
      chk("rst_flags", 64'({res_bubble, res_ovf}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Monotonic: 8 taps every snapshot
      run_meas(32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 6'd8, 1'b0, 1'b0, 0);
      // Averaging with truncation: 39/4 = 9
      run_meas(32'h0000_00FF, 32'h0000_01FF, 32'h0000_03FF, 32'h0000_0FFF, 6'd9, 1'b0, 1'b0, 0);
      // Bubble: lowest zero at bit 3, popcount 8
`ifdef TDC_BUBBLE_CORRECT_EN
      run_meas(32'h0000_01F7, 32'h0000_01F7, 32'h0000_01F7, 32'h0000_01F7, 6'd8, 1'b1, 1'b0, 0);
`else
      run_meas(32'h0000_01F7, 32'h0000_01F7, 32'h0000_01F7, 32'h0000_01F7, 6'd3, 1'b1, 1'b0, 0);
`endif
      // Saturation plus zeros: (32+0+0+0)/4 = 8
      run_meas(32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6'd8, 1'b0, 1'b1, 0);
      // Backpressure with both flags: 32+1+1+2=36 or 32+2+1+2=37, both give 9
      run_meas(32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0001, 32'h0000_0003, 6'd9, 1'b1, 1'b1, 10);

      // Reset during the second snapshot's pulse, after a saturated first snapshot
      meas_req = 1'b1;
      @(negedge clk);
      meas_req  = 1'b0;
      tdc_count = 32'hFFFF_FFFF;
      wait_start(1'b0);
      wait_start(1'b1);
      chk("pre_rst_start", 64'(tdc_start), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_start", 64'(tdc_start), 64'd0);
      chk("rst_mid_busy", 64'(meas_busy), 64'd0);
      chk("rst_mid_valid", 64'(res_valid), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      run_meas(32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 6'd4, 1'b0, 1'b0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
